overlap_add_accumulator: RTL and testbench
==========================================

// Module: overlap_add_accumulator
// PURPOSE
//   Parametrised overlap-add stage for strided transposed-convolution columns.
//   Each beat carries N_COL_FEATURE kernel-column segments. Every strobed segment j is added into an output-row buffer at pixel offset j*STRIDE.
//   Beats accumulate until N_BEATS beats or in_last. The finished row is then presented on a valid/ready output.
//   Sits between the PE-array partial-product output and the output-feature writeback.
// PARAMETERS
//   BIT_WIDTH      8   operand width; input element width IN_W = 2*BIT_WIDTH (signed)
//   N_COL_FEATURE  8   segments per beat
//   N_COL_KERNEL   5   elements per segment
//   STRIDE         2   pixel offset between adjacent segments (1..N_COL_KERNEL)
//   N_BEATS        4   beats accumulated per output row (>=1)
//   GUARD_BITS     4   accumulator growth; ACC_W = IN_W + GUARD_BITS
//   derived: N_PIX_IN = N_COL_FEATURE*N_COL_KERNEL; N_PIX_OUT = (N_COL_FEATURE-1)*STRIDE + N_COL_KERNEL; CNT_W = $clog2(N_BEATS+1)
// PORTS
//   clk        in   1                clock, all state on posedge
//   rst_n      in   1                reset, synchronous, active-low
//   in_valid   in   1                input beat valid
//   in_ready   out  1                input beat accepted when in_valid&in_ready
//   in_strobe  in   N_COL_FEATURE    bit j: segment j participates
//   in_last    in   1                close row after this beat (early terminate)
//   in_data    in   IN_W*N_PIX_IN    segment j = in_data[j*IN_W*N_COL_KERNEL +: IN_W*N_COL_KERNEL]; element k is LSB-first
//   out_valid  out  1                row ready
//   out_ready  in   1                consumer accepts row
//   out_data   out  ACC_W*N_PIX_OUT  pixel p = out_data[p*ACC_W +: ACC_W], signed
//   out_beats  out  CNT_W            beats accumulated into presented row
//   sat_flag   out  1                some pixel of presented row saturated (SATURATE_EN only; else 0)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_beats=0, sat_flag=0, beat_cnt=0, state=ACCUM. Applies mid-row; the partial row is discarded.
//   - States: ACCUM (out_valid=0), HOLD (out_valid=1).
//   - in_ready = (state==ACCUM) | out_ready. Combinational from out_ready only.
//   - Beat contribution: pixel p += sum over strobed j with 0<=p-j*STRIDE<N_COL_KERNEL of sext(elem[j][p-j*STRIDE]).
//     Contribution is computed at full precision, then added to ACC_W.
//   - A zero in_strobe beat still counts as a beat.
//   - ACCUM + accepted beat: acc += contribution; beat_cnt++.
//     If beat_cnt==N_BEATS-1 or in_last, go to HOLD at the same edge: out_beats=beat_cnt+1, beat_cnt=0.
//   - Latency: row visible (out_valid=1) the cycle after the closing beat's edge.
//   - HOLD: out_data/out_beats/sat_flag stable while out_ready=0.
//   - HOLD & out_ready & no accepted beat: go to ACCUM, acc cleared to 0.
//   - HOLD & out_ready & accepted beat (simultaneous): the new row starts from that beat alone (acc = contribution, beat_cnt=1).
//     If that beat also closes its row (N_BEATS==1 or in_last), stay in HOLD with the new row.
//   - The accumulator and output register are the same storage; no double buffering.
// CONFIGURATION
//   SATURATE_EN defined: each pixel add clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     sat_flag is sticky across the row, cleared when a new row starts.
//   Undefined: adds wrap modulo 2^ACC_W; sat_flag tied 0.
// TESTING (defaults unless stated)
//   1 strobe=8'h01, seg0 elems all 1, in_last=1 -> next cycle out_valid=1, pix0..4=1, pix5..18=0, out_beats=1
//   2 strobe=8'hFF, all elems 1, in_last=1 -> pix0=1,pix1=1,pix2=2,pix4=3,pix5=2,pix17=1,pix18=1
//   3 4 beats strobe=8'h01 elems=3, in_last=0 -> out_valid only after 4th beat; pix0=12, out_beats=4
//   4 hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable. Then out_ready=1 with in_valid=1 (elems 1, strobe 01) -> new pix0=1, not added to old row
//   5 N_BEATS=8, strobe=8'hFF, elems 16'h7FFF, 8 beats -> pix4: SATURATE_EN gives 524287 with sat_flag=1; undefined gives -262168 with sat_flag=0
//   6 2 beats accepted, then rst_n=0 for one posedge -> out_valid=0, out_data=0. Next 4 beats of 1 (strobe 01) -> pix0=4, no residue

Source files
------------

// File: rtl/overlap_add_accumulator.sv
// overlap_add_accumulator
//   Overlap-add stage for strided transposed-convolution columns. Each accepted
//   beat adds every strobed kernel-column segment j into an output-row buffer
//   at pixel offset j*STRIDE. A row closes after N_BEATS beats or on in_last,
//   and is then held on a valid/ready output until the consumer takes it.
//   The accumulator is also the output register (no double buffering).
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_strobe            per-segment participation mask
//   in_last              close the row after this beat
//   in_data              N_COL_FEATURE segments of N_COL_KERNEL signed IN_W elements
//   out_valid/out_ready  row handshake
//   out_data             N_PIX_OUT signed ACC_W pixels
//   out_beats            beats accumulated into the presented row
//   sat_flag             some pixel of the presented row saturated
//
// Build option
//   SATURATE_EN  defined: pixel adds clamp to the ACC_W signed range and
//                sat_flag is sticky across the row. Undefined: adds wrap and
//                sat_flag is tied low.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_ACCUM | accumulating beats, out_valid=0
// ST_HOLD  | finished row presented, out_valid=1

module overlap_add_accumulator #(
  parameter int BIT_WIDTH     = 8,
  parameter int N_COL_FEATURE = 8,
  parameter int N_COL_KERNEL  = 5,
  parameter int STRIDE        = 2,
  parameter int N_BEATS       = 4,
  parameter int GUARD_BITS    = 4,
  localparam int IN_W      = 2*BIT_WIDTH,
  localparam int ACC_W     = IN_W + GUARD_BITS,
  localparam int N_PIX_IN  = N_COL_FEATURE*N_COL_KERNEL,
  localparam int N_PIX_OUT = (N_COL_FEATURE-1)*STRIDE + N_COL_KERNEL,
  localparam int CNT_W     = $clog2(N_BEATS+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_COL_FEATURE-1:0]   in_strobe,
  input  logic                       in_last,
  input  logic [IN_W*N_PIX_IN-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W*N_PIX_OUT-1:0] out_data,
  output logic [CNT_W-1:0]           out_beats,
  output logic                       sat_flag
);

  localparam int SEG_W = IN_W*N_COL_KERNEL;
  // One pixel sees at most N_COL_FEATURE overlapping segments.
  localparam int SUM_W = IN_W + $clog2(N_COL_FEATURE+1);
  localparam int MAX_W = (ACC_W > SUM_W) ? ACC_W : SUM_W;
`ifdef SATURATE_EN
  // One extra bit so the clamp comparison sees the true overflowed sum.
  localparam int ADD_W = MAX_W + 1;
  localparam logic signed [ADD_W-1:0] SAT_MAX = ADD_W'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
  localparam logic signed [ADD_W-1:0] SAT_MIN = ADD_W'(-(64'sd1 <<< (ACC_W-1)));
`else
  localparam int ADD_W = MAX_W;
`endif

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]               r_state;
  logic [ACC_W*N_PIX_OUT-1:0] r_acc;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic [CNT_W-1:0]         r_out_beats;
  logic                     r_sat;

  logic                     w_accept;
  logic                     w_restart;
  logic                     w_close;
  logic [CNT_W-1:0]         w_base_cnt;
  logic                     w_sat_any;
  logic                     w_sat_nxt;
  logic [ACC_W*N_PIX_OUT-1:0] w_acc_nxt;
  logic signed [IN_W-1:0]   w_elem;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ADD_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_contrib [N_PIX_OUT];

  assign in_ready  = (r_state == ST_ACCUM) | out_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_acc;
  assign out_beats = r_out_beats;
  assign sat_flag  = r_sat;

  // Full-precision per-pixel contribution of the current beat.
  always_comb begin
    w_elem = '0;
    for (int p = 0; p < N_PIX_OUT; p++) w_contrib[p] = '0;
    for (int j = 0; j < N_COL_FEATURE; j++) begin
      for (int k = 0; k < N_COL_KERNEL; k++) begin
        w_elem = in_data[j*SEG_W + k*IN_W +: IN_W];
        if (in_strobe[j])
          w_contrib[j*STRIDE + k] = w_contrib[j*STRIDE + k] + SUM_W'(w_elem);
      end
    end
  end

  // A HOLD row that is being consumed restarts from zero, so a beat accepted
  // in the same cycle forms the first beat of the next row.
  always_comb begin
    w_accept   = in_valid & in_ready;
    w_restart  = (r_state == ST_HOLD) & out_ready;
    w_base_cnt = w_restart ? '0 : r_beat_cnt;
    w_close    = w_accept & ((w_base_cnt == CNT_W'(N_BEATS-1)) | in_last);
    w_sat_any  = 1'b0;
    w_acc_nxt  = '0;
    w_base     = '0;
    w_sum      = '0;
    for (int p = 0; p < N_PIX_OUT; p++) begin
      w_base = w_restart ? '0 : r_acc[p*ACC_W +: ACC_W];
      w_sum  = ADD_W'(w_base) + ADD_W'(w_contrib[p]);
      if (w_accept) begin
`ifdef SATURATE_EN
        if (w_sum > SAT_MAX) begin
          w_acc_nxt[p*ACC_W +: ACC_W] = SAT_MAX[ACC_W-1:0];
          w_sat_any = 1'b1;
        end else if (w_sum < SAT_MIN) begin
          w_acc_nxt[p*ACC_W +: ACC_W] = SAT_MIN[ACC_W-1:0];
          w_sat_any = 1'b1;
        end else begin
          w_acc_nxt[p*ACC_W +: ACC_W] = w_sum[ACC_W-1:0];
        end
`else
        w_acc_nxt[p*ACC_W +: ACC_W] = w_sum[ACC_W-1:0];
`endif
      end else begin
        w_acc_nxt[p*ACC_W +: ACC_W] = w_base;
      end
    end
    w_sat_nxt = (w_restart ? 1'b0 : r_sat) | w_sat_any;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_out_beats <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_sat <= w_sat_nxt;
      if (w_accept) begin
        if (w_close) begin
          r_state     <= ST_HOLD;
          r_out_beats <= w_base_cnt + CNT_W'(1);
          r_beat_cnt  <= '0;
        end else begin
          r_state    <= ST_ACCUM;
          r_beat_cnt <= w_base_cnt + CNT_W'(1);
        end
      end else if (w_restart) begin
        r_state    <= ST_ACCUM;
        r_beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_overlap_add_accumulator.sv
// tb_overlap_add_accumulator
//   Directed bench for overlap_add_accumulator. dut_a uses default parameters,
//   dut_b uses N_BEATS=8 for the saturation/wrap row. Expected values are
//   hand-computed for STRIDE=2, N_COL_KERNEL=5, ACC_W=20.

module tb_overlap_add_accumulator;

  localparam int ACC_W = 20;
  localparam int NPIX  = 19;

  logic                  clk;
  logic                  rst_n;
  logic                  a_in_valid, b_in_valid;
  logic                  a_in_ready, b_in_ready;
  logic [7:0]            in_strobe;
  logic                  in_last;
  logic [16*40-1:0]      in_data;
  logic                  out_ready;
  logic                  a_out_valid, b_out_valid;
  logic [ACC_W*NPIX-1:0] a_out_data, b_out_data;
  logic [2:0]            a_out_beats;
  logic [3:0]            b_out_beats;
  logic                  a_sat, b_sat;

  int n_checks = 0;
  int n_errors = 0;

  overlap_add_accumulator dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_strobe(in_strobe), .in_last(in_last), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_beats(a_out_beats), .sat_flag(a_sat)
  );

  overlap_add_accumulator #(.N_BEATS(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_strobe(in_strobe), .in_last(in_last), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_beats(b_out_beats), .sat_flag(b_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint pix_a(input int p);
    logic signed [ACC_W-1:0] v;
    v = a_out_data[p*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  function automatic longint pix_b(input int p);
    logic signed [ACC_W-1:0] v;
    v = b_out_data[p*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  task automatic load(input logic [7:0] strobe, input logic [15:0] val, input logic last);
    in_strobe = strobe;
    in_last   = last;
    for (int e = 0; e < 40; e++) in_data[e*16 +: 16] = val;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic beat_a(input logic [7:0] strobe, input logic [15:0] val, input logic last);
    load(strobe, val, last);
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] strobe, input logic [15:0] val, input logic last);
    load(strobe, val, last);
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic release_row();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  longint exp_pix4;
  longint exp_sat;

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; out_ready = 1'b0;
    load(8'h00, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", longint'(|a_out_data), 0);
    check("rst_out_beats", a_out_beats, 0);
    check("rst_sat", a_sat, 0);
    check("rst_in_ready", a_in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single segment, early close
    beat_a(8'h01, 16'd1, 1'b1);
    check("t1_valid", a_out_valid, 1);
    check("t1_pix0", pix_a(0), 1);
    check("t1_pix4", pix_a(4), 1);
    check("t1_pix5", pix_a(5), 0);
    check("t1_pix18", pix_a(18), 0);
    check("t1_beats", a_out_beats, 1);
    check("t1_in_ready_hold", a_in_ready, 0);
    release_row();
    check("t1_rel_valid", a_out_valid, 0);
    check("t1_rel_cleared", pix_a(0), 0);

    // 2: all segments overlap-add
    beat_a(8'hFF, 16'd1, 1'b1);
    check("t2_pix0", pix_a(0), 1);
    check("t2_pix1", pix_a(1), 1);
    check("t2_pix2", pix_a(2), 2);
    check("t2_pix4", pix_a(4), 3);
    check("t2_pix5", pix_a(5), 2);
    check("t2_pix16", pix_a(16), 2);
    check("t2_pix17", pix_a(17), 1);
    check("t2_pix18", pix_a(18), 1);
    release_row();

    // 3: N_BEATS close
    for (int b = 0; b < 3; b++) begin
      beat_a(8'h01, 16'd3, 1'b0);
      check("t3_not_valid", a_out_valid, 0);
    end
    beat_a(8'h01, 16'd3, 1'b0);
    check("t3_valid", a_out_valid, 1);
    check("t3_pix0", pix_a(0), 12);
    check("t3_pix4", pix_a(4), 12);
    check("t3_pix5", pix_a(5), 0);
    check("t3_beats", a_out_beats, 4);

    // 4: back-pressure, then simultaneous consume + new beat
    load(8'h01, 16'd1, 1'b0);
    a_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t4_in_ready", a_in_ready, 0);
      check("t4_hold_pix0", pix_a(0), 12);
    end
    check("t4_hold_beats", a_out_beats, 4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; out_ready = 1'b0;
    check("t4_new_valid", a_out_valid, 0);
    check("t4_new_pix0", pix_a(0), 1);
    for (int b = 0; b < 3; b++) beat_a(8'h01, 16'd1, 1'b0);
    check("t4_row_valid", a_out_valid, 1);
    check("t4_row_pix0", pix_a(0), 4);
    check("t4_row_beats", a_out_beats, 4);
    // consume and close a one-beat row in the same cycle
    load(8'h01, 16'd2, 1'b1);
    a_in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; out_ready = 1'b0;
    check("t4b_valid", a_out_valid, 1);
    check("t4b_pix0", pix_a(0), 2);
    check("t4b_beats", a_out_beats, 1);
    release_row();

    // 6: reset mid-row
    beat_a(8'h01, 16'd1, 1'b0);
    beat_a(8'h01, 16'd1, 1'b0);
    check("t6_partial_pix0", pix_a(0), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_rst_valid", a_out_valid, 0);
    check("t6_rst_data", longint'(|a_out_data), 0);
    for (int b = 0; b < 3; b++) begin
      beat_a(8'h01, 16'd1, 1'b0);
      check("t6_not_valid", a_out_valid, 0);
    end
    beat_a(8'h01, 16'd1, 1'b0);
    check("t6_valid", a_out_valid, 1);
    check("t6_pix0", pix_a(0), 4);
    check("t6_beats", a_out_beats, 4);
    release_row();

    // 5: N_BEATS=8 large values on dut_b
`ifdef SATURATE_EN
    exp_pix4 = 524287;  exp_sat = 1;
`else
    exp_pix4 = -262168; exp_sat = 0;
`endif
    for (int b = 0; b < 7; b++) beat_b(8'hFF, 16'h7FFF, 1'b0);
    check("t5_not_valid", b_out_valid, 0);
    beat_b(8'hFF, 16'h7FFF, 1'b0);
    check("t5_valid", b_out_valid, 1);
    check("t5_beats", b_out_beats, 8);
    check("t5_pix0", pix_b(0), 262136);
    check("t5_pix4", pix_b(4), exp_pix4);
    check("t5_sat", b_sat, exp_sat);
    release_row();
    check("t5_sat_cleared", b_sat, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
